// File: rtl/pdp8_tx_arb.sv
// Two-requester arbiter sharing one PDP-8 UART transmitter over 4-phase handshakes.
// tx_req rises 1 clk after a sampled request; requesters stall on ackN until the UART acks.
module pdp8_tx_arb #(
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [7:0] data0,
   output logic       ack0,
   output logic       empty0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       ack1,
   output logic       empty1,
   output logic       tx_req,
   output logic [7:0] tx_data,
   input  logic       tx_ack,
   input  logic       tx_empty,
   output logic [1:0] grant,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      ACKW  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t     state_q;
   logic [1:0] grant_q;
   logic [7:0] tx_data_q;
   logic       last_grant_q;
   logic       win1_d;

   // Requester 1 wins if it is alone, or on contention when requester 0 went last.
   always_comb begin
      win1_d = 1'b0;
      if (PRIO_FIXED) begin
         win1_d = req1 && !req0;
      end else begin
         win1_d = req1 && (!req0 || !last_grant_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= 2'b00;
         tx_data_q    <= 8'h00;
         last_grant_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  state_q      <= REQ;
                  grant_q      <= win1_d ? 2'b10 : 2'b01;
                  tx_data_q    <= win1_d ? data1 : data0;
                  last_grant_q <= win1_d;
               end
            end
            REQ: begin
               if (tx_ack) begin
                  state_q <= ACKW;
               end
            end
            ACKW: begin
               if (!tx_ack) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               // Returning to IDLE forces one idle cycle before the next grant.
               if (tx_empty) begin
                  state_q <= IDLE;
                  grant_q <= 2'b00;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

   logic ack_window;
   assign ack_window = (state_q == REQ) || (state_q == ACKW);

   assign tx_req  = (state_q == REQ);
   assign tx_data = tx_data_q;
   assign grant   = grant_q;
   assign busy    = (state_q != IDLE);
   assign ack0    = tx_ack && grant_q[0] && ack_window;
   assign ack1    = tx_ack && grant_q[1] && ack_window;
   assign empty0  = (state_q == IDLE) && tx_empty;
   assign empty1  = (state_q == IDLE) && tx_empty;

endmodule

// File: tb/tb_pdp8_tx_arb.sv
// Bench for pdp8_tx_arb: round-robin and fixed-priority instances share all inputs.
module tb_pdp8_tx_arb;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       tx_ack = 1'b0, tx_empty = 1'b1;

   logic       rr_ack0, rr_ack1, rr_empty0, rr_empty1, rr_tx_req, rr_busy;
   logic [7:0] rr_tx_data;
   logic [1:0] rr_grant;
   logic       fx_ack0, fx_ack1, fx_empty0, fx_empty1, fx_tx_req, fx_busy;
   logic [7:0] fx_tx_data;
   logic [1:0] fx_grant;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pdp8_tx_arb #(.PRIO_FIXED(1'b0)) dut_rr (
      .clk(clk), .reset(reset),
      .req0(req0), .data0(data0), .ack0(rr_ack0), .empty0(rr_empty0),
      .req1(req1), .data1(data1), .ack1(rr_ack1), .empty1(rr_empty1),
      .tx_req(rr_tx_req), .tx_data(rr_tx_data), .tx_ack(tx_ack), .tx_empty(tx_empty),
      .grant(rr_grant), .busy(rr_busy)
   );

   pdp8_tx_arb #(.PRIO_FIXED(1'b1)) dut_fx (
      .clk(clk), .reset(reset),
      .req0(req0), .data0(data0), .ack0(fx_ack0), .empty0(fx_empty0),
      .req1(req1), .data1(data1), .ack1(fx_ack1), .empty1(fx_empty1),
      .tx_req(fx_tx_req), .tx_data(fx_tx_data), .tx_ack(tx_ack), .tx_empty(tx_empty),
      .grant(fx_grant), .busy(fx_busy)
   );

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: a transaction is open, then acked, then released, then closed.
   bit         m_valid = 1'b0;
   bit         m_open = 1'b0, m_acked = 1'b0, m_released = 1'b0;
   int         m_owner [2];
   int         m_last  [2];
   logic [7:0] m_data  [2];

   function automatic int pick(input int k, input int last);
      if (req0 && req1) return (k == 1) ? 0 : ((last == 0) ? 1 : 0);
      return req0 ? 0 : 1;
   endfunction

   always @(posedge clk) begin
      m_valid = 1'b1;
      if (reset) begin
         m_open = 1'b0; m_acked = 1'b0; m_released = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_last[k] = 1; m_data[k] = 8'h00; m_owner[k] = 0;
         end
      end else if (!m_open) begin
         if (req0 || req1) begin
            for (int k = 0; k < 2; k++) begin
               m_owner[k] = pick(k, m_last[k]);
               m_last[k]  = m_owner[k];
               m_data[k]  = (m_owner[k] == 1) ? data1 : data0;
            end
            m_open = 1'b1; m_acked = 1'b0; m_released = 1'b0;
         end
      end else if (!m_acked) begin
         if (tx_ack) m_acked = 1'b1;
      end else if (!m_released) begin
         if (!tx_ack) m_released = 1'b1;
      end else if (tx_empty) begin
         m_open = 1'b0;
      end
   end

   task automatic check_inst(input string nm, input int k, input logic a0, input logic a1,
                             input logic e0, input logic e1, input logic tr,
                             input logic [7:0] td, input logic [1:0] g, input logic b);
      logic       live;
      logic [1:0] eg;
      live = m_open && !m_released;
      eg   = !m_open ? 2'b00 : (m_owner[k] == 1 ? 2'b10 : 2'b01);
      cmp({nm, ".tx_req"}, 32'(tr), 32'(m_open && !m_acked));
      cmp({nm, ".busy"}, 32'(b), 32'(m_open));
      cmp({nm, ".grant"}, 32'(g), 32'(eg));
      cmp({nm, ".tx_data"}, 32'(td), 32'(m_data[k]));
      cmp({nm, ".ack0"}, 32'(a0), 32'(tx_ack && live && m_owner[k] == 0));
      cmp({nm, ".ack1"}, 32'(a1), 32'(tx_ack && live && m_owner[k] == 1));
      cmp({nm, ".empty0"}, 32'(e0), 32'(!m_open && tx_empty));
      cmp({nm, ".empty1"}, 32'(e1), 32'(!m_open && tx_empty));
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         check_inst("rr", 0, rr_ack0, rr_ack1, rr_empty0, rr_empty1, rr_tx_req, rr_tx_data, rr_grant, rr_busy);
         check_inst("fx", 1, fx_ack0, fx_ack1, fx_empty0, fx_empty1, fx_tx_req, fx_tx_data, fx_grant, fx_busy);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   // Called just after the grant edge; returns just after the edge that re-enters IDLE.
   task automatic run_uart(input int ack_dly, input int drain_dly, input logic [1:0] exp_g);
      repeat (ack_dly) cyc();
      tx_ack = 1'b1;
      tx_empty = 1'b0;
      @(negedge clk);
      cmp("uart.ack0", 32'(rr_ack0), 32'(exp_g[0]));
      cmp("uart.ack1", 32'(rr_ack1), 32'(exp_g[1]));
      cyc();
      tx_ack = 1'b0;
      repeat (drain_dly) cyc();
      tx_empty = 1'b1;
      @(negedge clk);
      cmp("uart.drain_busy", 32'(rr_busy), 32'd1);
      cyc();
   endtask

   logic [1:0] rr_order [6];
   logic [1:0] fx_order [6];
   logic [1:0] exp_order [6];

   initial begin
      exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
      exp_order[3] = 2'b10; exp_order[4] = 2'b01; exp_order[5] = 2'b10;

      cyc(); cyc();
      reset = 1'b0;
      @(negedge clk);
      cmp("rst.busy", 32'(rr_busy), 32'd0);
      cmp("rst.tx_req", 32'(rr_tx_req), 32'd0);
      cmp("rst.tx_data", 32'(rr_tx_data), 32'h00);
      cmp("rst.grant", 32'(rr_grant), 32'd0);
      cmp("rst.empty0", 32'(rr_empty0), 32'd1);

      // Single transaction from requester 0.
      cyc();
      req0 = 1'b1; data0 = 8'h41;
      cyc();
      @(negedge clk);
      cmp("single.tx_req", 32'(rr_tx_req), 32'd1);
      cmp("single.tx_data", 32'(rr_tx_data), 32'h41);
      cmp("single.grant", 32'(rr_grant), 32'b01);
      req0 = 1'b0;
      run_uart(3, 10, 2'b01);
      @(negedge clk);
      cmp("single.empty0", 32'(rr_empty0), 32'd1);
      cmp("single.idle_grant", 32'(rr_grant), 32'd0);

      // Contention: both request continuously for six transactions.
      do_reset();
      req0 = 1'b1; req1 = 1'b1; data0 = 8'h30; data1 = 8'h31;
      for (int i = 0; i < 6; i++) begin
         cyc();
         @(negedge clk);
         rr_order[i] = rr_grant;
         fx_order[i] = fx_grant;
         run_uart(1, 2, exp_order[i]);
      end
      req0 = 1'b0; req1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cmp($sformatf("rr.order%0d", i), 32'(rr_order[i]), 32'(exp_order[i]));
         cmp($sformatf("fx.order%0d", i), 32'(fx_order[i]), 32'b01);
      end
      cyc();

      // Granted request dropped before the UART acks.
      req0 = 1'b1; data0 = 8'h5A;
      cyc();
      req0 = 1'b0; data0 = 8'hFF;
      cyc();
      @(negedge clk);
      cmp("drop.busy", 32'(rr_busy), 32'd1);
      cmp("drop.tx_data", 32'(rr_tx_data), 32'h5A);
      run_uart(2, 3, 2'b01);
      @(negedge clk);
      cmp("drop.done", 32'(rr_busy), 32'd0);
      cmp("drop.tx_data_held", 32'(rr_tx_data), 32'h5A);

      // Reset during ACKW, then requester 1 is granted immediately.
      req0 = 1'b1; data0 = 8'h11;
      cyc();
      tx_ack = 1'b1; tx_empty = 1'b0;
      cyc();
      @(negedge clk);
      cmp("rstmid.ackw_ack0", 32'(rr_ack0), 32'd1);
      reset = 1'b1; req0 = 1'b0; tx_ack = 1'b0; tx_empty = 1'b1;
      req1 = 1'b1; data1 = 8'h33;
      cyc();
      reset = 1'b0;
      @(negedge clk);
      cmp("rstmid.busy", 32'(rr_busy), 32'd0);
      cmp("rstmid.tx_req", 32'(rr_tx_req), 32'd0);
      cmp("rstmid.grant", 32'(rr_grant), 32'd0);
      cmp("rstmid.empty1", 32'(rr_empty1), 32'd1);
      cyc();
      @(negedge clk);
      cmp("rstmid.grant1", 32'(rr_grant), 32'b10);
      cmp("rstmid.tx_data", 32'(rr_tx_data), 32'h33);
      cmp("rstmid.tx_req1", 32'(rr_tx_req), 32'd1);
      req1 = 1'b0;
      run_uart(1, 1, 2'b10);

      // tx_ack already high entering REQ; tx_empty high throughout is ignored until DRAIN.
      tx_ack = 1'b1;
      req0 = 1'b1; data0 = 8'h77;
      cyc();
      @(negedge clk);
      cmp("ackhi.tx_req", 32'(rr_tx_req), 32'd1);
      cmp("ackhi.ack0", 32'(rr_ack0), 32'd1);
      req0 = 1'b0;
      cyc();
      @(negedge clk);
      cmp("ackhi.ackw_tx_req", 32'(rr_tx_req), 32'd0);
      cyc(); cyc();
      @(negedge clk);
      cmp("ackhi.still_ackw", 32'(rr_ack0), 32'd1);
      tx_ack = 1'b0;
      cyc();
      @(negedge clk);
      cmp("ackhi.drain_busy", 32'(rr_busy), 32'd1);
      cmp("ackhi.drain_ack0", 32'(rr_ack0), 32'd0);
      cyc();
      @(negedge clk);
      cmp("ackhi.idle", 32'(rr_busy), 32'd0);

      // Randomized traffic; the per-cycle model check does the work.
      for (int i = 0; i < 4000; i++) begin
         cyc();
         reset    = ($urandom_range(99) < 2);
         req0     = ($urandom_range(99) < 40);
         req1     = ($urandom_range(99) < 40);
         data0    = 8'($urandom);
         data1    = 8'($urandom);
         tx_ack   = ($urandom_range(99) < 35);
         tx_empty = ($urandom_range(99) < 50);
      end
      cyc();
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pdp8_tx_arb.md
PDP8_TX_ARB -- requirements
Module: pdp8_tx_arb

Interface
REQ-001 Parameter: PRIO_FIXED, default 0, meaning 0 = round-robin arbitration and 1 = requester 0 always wins a simultaneous request.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 (console TT) transmit request, 4-phase handshake.
REQ-005 data0  input  8  requester 0 character.
REQ-006 ack0  output  1  handshake acknowledge to requester 0.
REQ-007 empty0  output  1  transmitter-free indication to requester 0.
REQ-008 req1  input  1  requester 1 (secondary/monitor channel) transmit request.
REQ-009 data1  input  8  requester 1 character.
REQ-010 ack1  output  1  handshake acknowledge to requester 1.
REQ-011 empty1  output  1  transmitter-free indication to requester 1.
REQ-012 tx_req  output  1  request to the shared UART transmitter.
REQ-013 tx_data  output  8  latched character presented to the UART.
REQ-014 tx_ack  input  1  UART acknowledge.
REQ-015 tx_empty  input  1  UART transmitter holding/shift register empty.
REQ-016 grant  output  2  one-hot owner of the current transaction; 2'b00 when idle.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, ACKW and DRAIN, held in a register.
- IDLE -> REQ at a posedge where req0 or req1 is sampled high.
- REQ -> ACKW when tx_ack = 1.
- ACKW -> DRAIN when tx_ack = 0.
- DRAIN -> IDLE when tx_empty = 1.
- Otherwise the FSM SHALL hold its state.
REQ-019 At the IDLE->REQ edge the block SHALL latch the grant and tx_data from the winner's data; both SHALL hold for the whole transaction.
REQ-020 Winner selection, round-robin (PRIO_FIXED = 0):
- Single requester: that requester wins.
- Both requesting: the requester not equal to last_grant wins.
- last_grant SHALL update at the grant edge.
REQ-021 With PRIO_FIXED = 1, requester 0 SHALL win whenever req0 = 1.
REQ-022 tx_req SHALL equal (state == REQ), decoded combinationally from the state register.
REQ-023 ackN SHALL equal tx_ack AND grant[N] AND (state == REQ or ACKW); the non-granted ack SHALL stay 0.
REQ-024 emptyN SHALL equal (state == IDLE) AND tx_empty for both requesters.
REQ-025 grant SHALL be 2'b00 in IDLE and one-hot otherwise.
REQ-026 Deassertion of the granted req after the grant edge SHALL NOT abort the transaction; data already latched SHALL be sent.
REQ-027 A losing requester that holds req high SHALL be granted at the first IDLE cycle after the current transaction, with no added latency.
REQ-028 A new grant SHALL NOT occur in the same cycle as DRAIN->IDLE; there is a minimum of one IDLE cycle between transactions.
REQ-029 A tx_ack already high on entry to REQ SHALL advance the FSM to ACKW on the next edge.
REQ-030 tx_empty transitions outside DRAIN SHALL be ignored by the FSM.
REQ-031 Latency SHALL be 1 clk from a sampled req to tx_req = 1.

Reset
REQ-032 While reset = 1 at a posedge, the block SHALL set:
- state = IDLE
- tx_req = 0, tx_data = 8'h00, grant = 2'b00, busy = 0
- ack0 = ack1 = 0
- last_grant = 1, so requester 0 wins the first contention.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction at that edge with no further tx_req; emptyN SHALL follow tx_empty the next cycle.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- Single transaction: req0 = 1, data0 = 8'h41; UART acks after 3 clk and sets tx_empty 10 clk later. Required: tx_req high 1 clk after req0, tx_data = 8'h41, ack0 mirrors tx_ack, empty0 = 1 one clk after tx_empty, grant = 2'b01 throughout.
- Contention, round-robin: req0 and req1 asserted in the same cycle, three back-to-back transactions each. Required grant order: 01, 10, 01, 10, 01, 10; ack1 = 0 throughout every requester-0 transaction.
- PRIO_FIXED = 1, both continuously requesting. Required: grant stays 2'b01 for every transaction.
- req0 dropped one cycle after grant, before tx_ack. Required: transaction completes and tx_data stays at the latched value until IDLE.
- Reset pulsed during ACKW. Required: next cycle busy = 0, tx_req = 0, grant = 00, and a following req1 is granted after 1 clk.
- tx_ack held high on entry to REQ. Required: REQ->ACKW in 1 clk, then DRAIN only after tx_ack falls.
